// File: rtl/gate_unit_pkg.sv
// Shared types for gate_unit: gate op codes, sweep FSM states and op count.
package gate_unit_pkg;

    localparam int unsigned NUM_OPS = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOTA = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUFA = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        GAP   = 2'd2
    } gate_state_e;

endpackage

// File: rtl/gate_unit_if.sv
// Request/result handshake bundle for gate_unit; master is the operand source and
// result consumer side, slave is the gate unit itself.
interface gate_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_sweep;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_op;
    logic [WIDTH-1:0] out_result;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_op, in_sweep, input_a, input_b, out_ready,
        input  in_ready, out_valid, out_op, out_result, out_last, busy
    );

    modport slave (
        input  in_valid, in_op, in_sweep, input_a, input_b, out_ready,
        output in_ready, out_valid, out_op, out_result, out_last, busy
    );
endinterface

// File: rtl/gate_eval.sv
// Purely combinational bitwise gate evaluator: result = op(a, b) on every bit.
module gate_eval
    import gate_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  gate_op_e         op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOTA: result = ~a;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_BUFA: result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/gate_unit.sv
// Handshaked bitwise gate unit with a registered output stage. Define GATE_UNIT_SWEEP_EN
// to build the sweep mode that emits all eight gate results for one latched operand pair.
module gate_unit
    import gate_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input logic        clk,
    input logic        rst_n,
    gate_unit_if.slave bus
);

    logic             accept;
    logic             out_fire;
    logic [WIDTH-1:0] eval_a;
    logic [WIDTH-1:0] eval_b;
    logic [WIDTH-1:0] eval_res;
    gate_op_e         eval_op;

    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    gate_op_e         out_op_q, out_op_d;

    assign out_fire = out_valid_q & bus.out_ready;
    assign accept   = bus.in_valid & bus.in_ready;

    // One evaluator serves both paths; its inputs are steered by the FSM state.
    gate_eval #(
        .WIDTH (WIDTH)
    ) u_eval (
        .a      (eval_a),
        .b      (eval_b),
        .op     (eval_op),
        .result (eval_res)
    );

`ifdef GATE_UNIT_SWEEP_EN
    localparam int unsigned GapW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES - 1) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
    localparam logic [2:0] LastStep = 3'(NUM_OPS - 1);

    gate_state_e      state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sweep_req;

    assign sweep_req    = bus.in_sweep;
    assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.busy     = (state_q != IDLE);

    // In SWEEP the evaluator looks one step ahead so the next result is ready on handshake.
    always_comb begin
        eval_a  = a_q;
        eval_b  = b_q;
        eval_op = gate_op_e'(step_q);
        unique case (state_q)
            IDLE: begin
                eval_a  = bus.input_a;
                eval_b  = bus.input_b;
                eval_op = sweep_req ? OP_AND : gate_op_e'(bus.in_op);
            end
            SWEEP:   eval_op = gate_op_e'(step_q + 3'd1);
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        gap_d        = gap_q;
        a_d          = a_q;
        b_d          = b_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_last_d   = out_last_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    out_valid_d  = 1'b1;
                    out_result_d = eval_res;
                    out_op_d     = eval_op;
                    out_last_d   = !sweep_req;
                    if (sweep_req) begin
                        state_d = SWEEP;
                        step_d  = '0;
                        a_d     = bus.input_a;
                        b_d     = bus.input_b;
                    end
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
            end
            SWEEP: begin
                if (out_fire) begin
                    if (step_q == LastStep) begin
                        state_d     = IDLE;
                        step_d      = '0;
                        out_valid_d = 1'b0;
                    end else if (HOLD_CYCLES > 1) begin
                        state_d     = GAP;
                        gap_d       = '0;
                        step_d      = step_q + 3'd1;
                        out_valid_d = 1'b0;
                    end else begin
                        step_d       = step_q + 3'd1;
                        out_result_d = eval_res;
                        out_op_d     = eval_op;
                        out_last_d   = (step_d == LastStep);
                    end
                end
            end
            GAP: begin
                if (gap_q == GapLast) begin
                    state_d      = SWEEP;
                    gap_d        = '0;
                    out_valid_d  = 1'b1;
                    out_result_d = eval_res;
                    out_op_d     = eval_op;
                    out_last_d   = (step_q == LastStep);
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            gap_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            gap_q   <= gap_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
`else
    logic unused_cfg;

    // Without sweep support in_sweep and the pacing parameter have no effect.
    assign unused_cfg   = bus.in_sweep ^ HOLD_CYCLES[0];
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign bus.busy     = 1'b0;
    assign eval_a       = bus.input_a;
    assign eval_b       = bus.input_b;
    assign eval_op      = gate_op_e'(bus.in_op);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_last_d   = out_last_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = eval_res;
            out_op_d     = eval_op;
            out_last_d   = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_op_q     <= OP_AND;
            out_last_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_op     = out_op_q;
    assign bus.out_last   = out_last_q;

endmodule

// File: doc/gate_unit.md
# gate_unit

Parametrised, handshaked bitwise logic unit evaluating eight two-operand gate functions on WIDTH-bit operands. Results leave through a registered valid/ready output stage. An optional sweep mode latches one operand pair and emits all eight gate results in sequence, with a programmable gap between them, for display or self-test. The block sits between an operand source (switches or upstream logic) and a result consumer (LED driver, display mux or downstream datapath).

## Interface
- WIDTH, 8: operand/result width in bits; ≥1.
- HOLD_CYCLES, 1: sweep pacing; ≥1. HOLD_CYCLES−1 idle cycles are inserted between consecutive sweep results.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  3  gate select for single-op requests.
- in_sweep  in  1  request is a full sweep (ignored when sweep is compiled out).
- input_a  in  WIDTH  operand A.
- input_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_op  out  3  op code that produced out_result.
- out_result  out  WIDTH  gate result.
- out_last  out  1  final result of a request.
- busy  out  1  sweep in progress (state ≠ IDLE).

## Operation
- Op encoding, bitwise on all WIDTH bits:
  - 0 AND, 1 OR, 2 XOR, 3 NOT A, 4 NAND, 5 NOR, 6 XNOR, 7 BUF A.
  - All 8 codes are legal.
- Accept a request on in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Single op (in_sweep=0):
  - Result, op and out_last=1 are registered at the accept edge.
- Sweep (in_sweep=1):
  - Operands are latched at accept; the block enters SWEEP with step=0 and presents op 0.
  - Each out handshake advances the step.
  - Operand changes after accept have no effect.
- FSM states:
  - IDLE → SWEEP on a sweep accept.
  - SWEEP, on handshake of step<7: → GAP if HOLD_CYCLES>1, else stay in SWEEP and present step+1.
  - GAP counts HOLD_CYCLES−1 cycles with out_valid=0, then → SWEEP presenting step+1.
  - SWEEP, on handshake of step 7 (out_last=1): → IDLE.
- Output is held stable (out_result, out_op, out_last) while out_valid && !out_ready.
- A new single op may be accepted in the same cycle the current result drains.

## Timing
- Reset values:
  - out_valid=0, out_result=0, out_op=0, out_last=0, busy=0.
  - State IDLE; step and gap counter 0.
  - in_ready reads 1 while in reset.
- Latency: accept at edge N → out_valid high after edge N (one cycle).
- Single-op throughput: one result per cycle with out_ready held high.
- Sweep duration, out_ready=1: 8 + 7·(HOLD_CYCLES−1) cycles from first out_valid to the last result's handshake.
- Reset mid-sweep: aborts immediately (asynchronous); no partial state survives release.
- out_ready low across a step boundary: no step is skipped or repeated.

## Configuration
- GATE_UNIT_SWEEP_EN defined:
  - Sweep mode, SWEEP/GAP states, step counter and gap counter are present.
- GATE_UNIT_SWEEP_EN not defined:
  - in_sweep is ignored; every request is single-op.
  - busy is tied to 0.
  - No sweep logic is synthesised.

## Structure
- Package gate_unit_pkg holds:
  - gate_op_e, a 3-bit enum OP_AND … OP_BUFA.
  - gate_state_e (IDLE, SWEEP, GAP).
  - Op count constant NUM_OPS=8.
- Sub-module gate_eval: purely combinational, WIDTH-parametrised; (a, b, op) → result.
  - Used for both the single-op path and the sweep path.

## Test plan
- WIDTH=8, a=0xF0, b=0xCC, op=0 → next cycle out_result=0xC0, out_op=0, out_last=1.
- Sweep, a=0xF0, b=0xCC, out_ready=1, HOLD_CYCLES=1:
  - Results on 8 consecutive cycles: 0xC0, 0xFC, 0x3C, 0x0F, 0x3F, 0x03, 0xC3, 0xF0.
  - out_last is high on the 8th result only; in_ready=0 throughout.
- Same sweep, out_ready low 5 cycles at step 3 → out_result=0x0F, out_op=3 held stable; the full 8-result sequence is intact.
- HOLD_CYCLES=4 sweep → 3 out_valid-low cycles between results; 29 cycles from first valid to last handshake.
- rst_n low at sweep step 5:
  - out_valid=0, busy=0, out_result=0 without waiting for a clock edge.
  - After release, single op a=0x0F, b=0xFF, op=2 → 0xF0.
- Macro undefined, in_sweep=1, op=2, a=0xF0, b=0xCC → single result 0x3C with out_last=1; busy never asserts.
